// File: rtl/ray_stream_feeder.sv
// ray_stream_feeder
// -----------------
// Frame sequencer between the ray ROM and the ray tracer. Each frame it reads
// num_rays rays from a synchronous ROM of ROM_LAT cycles read latency. A small
// skid buffer absorbs the latency so that downstream backpressure never drops
// or repeats a ray. It then counts shaded pixels coming back from the tracer
// and pulses frame_done when a whole frame has been shaded. In loop mode the
// next frame starts automatically.
//
// Ports
//   clock, reset   system clock; asynchronous active-high reset
//   start          one-cycle pulse, begins a frame when idle
//   loop_mode      1 = restart automatically after every frame
//   num_rays       rays per frame, captured when a start is accepted
//   rom_addr       ROM read address (holds its value between reads)
//   rom_q          ROM read data, 6 components of D_BITS each
//   ray_out        head of the skid buffer, presented to the tracer
//   out_wr_en      ray_out is valid and is written this cycle
//   out_full       tracer input FIFO full
//   pix_wr_en      one shaded pixel returned by the tracer
//   busy           high whenever a frame is in progress
//   frame_done     one-cycle pulse at the end of each frame
//   frame_count    frames completed, wraps at 2^16
//   pix_overflow   sticky flag: a pixel arrived with none outstanding
module ray_stream_feeder #(
    parameter int D_BITS     = 16,
    parameter int ADDR_BITS  = 10,
    parameter int ROM_LAT    = 1,
    parameter int SKID_DEPTH = ROM_LAT + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loop_mode,
    input  logic [ADDR_BITS:0]    num_rays,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [6*D_BITS-1:0]   rom_q,
    output logic [6*D_BITS-1:0]   ray_out,
    output logic                  out_wr_en,
    input  logic                  out_full,
    input  logic                  pix_wr_en,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  pix_overflow
);

    localparam int RAY_W = 6 * D_BITS;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    // Wide enough for in_flight + buffered and for SKID_DEPTH + 1.
    localparam int OCC_W = $clog2(SKID_DEPTH + ROM_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_WAIT_PIX
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   num_rays_q, num_rays_d;
    logic [ADDR_BITS:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_BITS:0]   pix_cnt_q, pix_cnt_d;
    logic [ROM_LAT-1:0]   pipe_q, pipe_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_BITS-1:0] rom_addr_q;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 pix_overflow_q, pix_overflow_d;

    logic [RAY_W-1:0]     skid_q     [SKID_DEPTH];
    logic [RAY_W-1:0]     skid_d     [SKID_DEPTH];
    logic [RAY_W-1:0]     shift_src  [SKID_DEPTH];

    logic                 issue;
    logic                 pop;
    logic                 wr_en;
    logic                 credit_ok;
    logic                 done_now;
    logic [OCC_W-1:0]     in_flight;
    logic [CNT_W-1:0]     wr_idx;

    // Buffer head leaves when valid and the tracer can take it.
    assign pop   = (count_q != '0) && !out_full;
    // A valid bit leaving the pipe means rom_q carries that read's data now.
    assign wr_en = pipe_q[ROM_LAT-1];

    // Tail slot after this cycle's pop has shifted the buffer down.
    assign wr_idx = count_q - {{(CNT_W-1){1'b0}}, pop};

    // Outstanding reads in the ROM pipe.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            in_flight = in_flight + {{(OCC_W-1){1'b0}}, pipe_q[i]};
        end
    end

    // A slot freed by a same-cycle pop is reusable immediately, which keeps
    // the stream at one ray per cycle while still never overfilling the buffer.
    assign credit_ok = (in_flight + OCC_W'(count_q)) <
                       (OCC_W'(SKID_DEPTH) + {{(OCC_W-1){1'b0}}, pop});

    // Sequencer next state.
    always_comb begin
        state_d        = state_q;
        num_rays_d     = num_rays_q;
        issue_cnt_d    = issue_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        frame_count_d  = frame_count_q;
        pix_overflow_d = pix_overflow_q;
        issue          = 1'b0;
        done_now       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (num_rays != '0)) begin
                    num_rays_d  = num_rays;
                    issue_cnt_d = '0;
                    pix_cnt_d   = '0;
                    state_d     = S_FEED;
                end
            end
            S_FEED: begin
                if ((issue_cnt_q < num_rays_q) && credit_ok) begin
                    issue       = 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if ((issue_cnt_q + 1'b1) == num_rays_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((pipe_q == '0) && (count_q == '0)) begin
                    state_d = S_WAIT_PIX;
                end
            end
            S_WAIT_PIX: begin
                if (pix_cnt_q == num_rays_q) begin
                    done_now      = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    if (loop_mode) begin
                        issue_cnt_d = '0;
                        pix_cnt_d   = '0;
                        state_d     = S_FEED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pixel accounting; a pixel with nothing outstanding is flagged.
        // In the frame-done cycle pix_cnt_q == num_rays_q, so the counter
        // clear above is never overwritten here.
        if (pix_wr_en) begin
            if ((state_q != S_IDLE) && (pix_cnt_q != num_rays_q)) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end else begin
                pix_overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ROM valid-bit pipe.
    assign pipe_d[0] = issue;
    for (genvar gi = 1; gi < ROM_LAT; gi++) begin : g_pipe
        assign pipe_d[gi] = pipe_q[gi-1];
    end

    // Skid buffer as a shift-down FIFO: entry 0 is always the head.
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
        if (gi < SKID_DEPTH - 1) begin : g_mid
            assign shift_src[gi] = skid_q[gi+1];
        end else begin : g_last
            assign shift_src[gi] = skid_q[gi];
        end
        assign skid_d[gi] = (wr_en && (wr_idx == CNT_W'(gi))) ? rom_q :
                            (pop ? shift_src[gi] : skid_q[gi]);
    end

    // rom_addr follows the issue counter on a read and otherwise holds.
    assign rom_addr = issue ? issue_cnt_q[ADDR_BITS-1:0] : rom_addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            num_rays_q     <= '0;
            issue_cnt_q    <= '0;
            pix_cnt_q      <= '0;
            pipe_q         <= '0;
            count_q        <= '0;
            rom_addr_q     <= '0;
            frame_count_q  <= '0;
            pix_overflow_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            num_rays_q     <= num_rays_d;
            issue_cnt_q    <= issue_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            pipe_q         <= pipe_d;
            count_q        <= count_d;
            rom_addr_q     <= rom_addr;
            frame_count_q  <= frame_count_d;
            pix_overflow_q <= pix_overflow_d;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= skid_d[i];
            end
        end
    end

    assign ray_out      = skid_q[0];
    assign out_wr_en    = pop;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = done_now;
    assign frame_count  = frame_count_q;
    assign pix_overflow = pix_overflow_q;

endmodule

// File: tb/tb_ray_stream_feeder.sv
// Testbench for ray_stream_feeder: ROM_LAT=2, ADDR_BITS=4 (16-ray full frame).
// Expected rays are queued when a frame is started and popped as the DUT
// emits them.
module tb_ray_stream_feeder;

    localparam int D_BITS    = 16;
    localparam int ADDR_BITS = 4;
    localparam int ROM_LAT   = 2;
    localparam int RAY_W     = 6 * D_BITS;

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic                 loop_mode;
    logic [ADDR_BITS:0]   num_rays;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [RAY_W-1:0]     rom_q;
    logic [RAY_W-1:0]     ray_out;
    logic                 out_wr_en;
    logic                 out_full;
    logic                 pix_wr_en;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          frame_count;
    logic                 pix_overflow;

    ray_stream_feeder #(
        .D_BITS    (D_BITS),
        .ADDR_BITS (ADDR_BITS),
        .ROM_LAT   (ROM_LAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .loop_mode    (loop_mode),
        .num_rays     (num_rays),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .ray_out      (ray_out),
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .pix_wr_en    (pix_wr_en),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .pix_overflow (pix_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Distinct ray word for every address.
    function automatic logic [RAY_W-1:0] rom_word(input int a);
        logic [RAY_W-1:0] w;
        for (int i = 0; i < 6; i++) begin
            w[D_BITS*i +: D_BITS] = 16'(16'h3C00 + (a << 4) + i + a * i * 3);
        end
        return w;
    endfunction

    // Synchronous ROM, two cycles address to data.
    logic [RAY_W-1:0] rom_p0, rom_p1;
    always @(posedge clock) begin
        rom_p0 <= rom_word(int'(rom_addr));
        rom_p1 <= rom_p0;
    end
    assign rom_q = rom_p1;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int pend     = 0;
    logic [RAY_W-1:0] exp_q [$];
    logic [RAY_W-1:0] exp_w;

    // Snapshots of the cycle just finished.
    logic                 s_wr, s_busy, s_done;
    logic [ADDR_BITS-1:0] s_addr;

    task automatic push_frame(input int n);
        for (int a = 0; a < n; a++) exp_q.push_back(rom_word(a));
    endtask

    // One clock cycle: sample at negedge, consume scoreboard, return at posedge+1.
    task automatic tick();
        @(negedge clock);
        s_wr   = out_wr_en;
        s_busy = busy;
        s_done = frame_done;
        s_addr = rom_addr;
        if (out_wr_en) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ray_unexpected cycle=%0d got=%h required=none", cyc_n, ray_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (ray_out !== exp_w) begin
                    failures++;
                    $display("FAIL ray_order cycle=%0d got=%h required=%h", cyc_n, ray_out, exp_w);
                end
            end
        end
        if (frame_done) done_cnt++;
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    // Returns one pixel per emitted ray until the frame ends.
    task automatic run_with_pixels(input int budget, input bit rand_full);
        for (int c = 0; c < budget; c++) begin
            pix_wr_en = (pend > 0);
            if (pix_wr_en) pend--;
            out_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            if (s_wr) pend++;
            if (!busy && pend == 0) break;
        end
        pix_wr_en = 1'b0;
        out_full  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; loop_mode = 1'b0; num_rays = '0;
        out_full = 1'b0; pix_wr_en = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, out_wr_en, frame_done, pix_overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000", {busy, out_wr_en, frame_done, pix_overflow});
        end
        checks++;
        if (frame_count !== 16'd0 || ray_out !== '0 || rom_addr !== '0) begin
            failures++;
            $display("FAIL reset_values got=%0h/%0h/%0h required=0/0/0", frame_count, ray_out, rom_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        int w0;
        w0 = wr_cnt;
        push_frame(8);
        start = 1'b1; num_rays = 5'd8; loop_mode = 1'b0;
        cyc_n = 0;
        tick();
        start = 1'b0;
        checks++;
        if (s_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_cycle0 got=%b required=0", s_busy);
        end
        for (int c = 1; c <= 13; c++) begin
            tick();
            checks++;
            if (s_wr !== ((c >= 4) && (c <= 11))) begin
                failures++;
                $display("FAIL wr_timing cycle=%0d got=%b required=%b", c, s_wr, (c >= 4) && (c <= 11));
            end
            if (c == 1) begin
                checks++;
                if (s_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_cycle1 got=%b required=1", s_busy);
                end
            end
            if (c <= 8) begin
                checks++;
                if (s_addr !== ADDR_BITS'(c - 1)) begin
                    failures++;
                    $display("FAIL rom_addr cycle=%0d got=%0d required=%0d", c, s_addr, c - 1);
                end
            end
        end
        checks++;
        if (wr_cnt - w0 != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL latency_count got=%0d left=%0d required=8/0", wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_pixels();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            pix_wr_en = 1'b1;
            tick();
        end
        pix_wr_en = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL frame_done_pulses got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b0 || pix_overflow !== 1'b0) begin
            failures++;
            $display("FAIL frame_end got=%0d/%b/%b required=1/0/0", frame_count, busy, pix_overflow);
        end
        pix_wr_en = 1'b1;
        tick();
        pix_wr_en = 1'b0;
        tick();
        checks++;
        if (pix_overflow !== 1'b1) begin
            failures++;
            $display("FAIL pix_overflow got=%b required=1", pix_overflow);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = wr_cnt;
        push_frame(8);
        start = 1'b1; num_rays = 5'd8;
        cyc_n = 0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            out_full = (c >= 5) && (c <= 9);
            tick();
            if (c >= 5 && c <= 9) begin
                checks++;
                if (s_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL wr_while_full cycle=%0d got=%b required=0", c, s_wr);
                end
            end
        end
        out_full = 1'b0;
        checks++;
        if (wr_cnt - w0 != 8 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_count got=%0d left=%0d required=8/0", wr_cnt - w0, exp_q.size());
        end
        pend = 8;
        run_with_pixels(40, 1'b0);
        checks++;
        if (frame_count !== 16'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_end got=%0d/%b required=2/0", frame_count, busy);
        end
    endtask

    task automatic test_loop();
        int w0, d0;
        logic [15:0] fc0;
        logic [ADDR_BITS-1:0] prev;
        int addr_log [$];
        w0 = wr_cnt; d0 = done_cnt; fc0 = frame_count; pend = 0;
        prev = rom_addr;
        push_frame(4);
        loop_mode = 1'b1; start = 1'b1; num_rays = 5'd4;
        for (int c = 0; c < 150; c++) begin
            pix_wr_en = (pend > 0);
            if (pix_wr_en) pend--;
            tick();
            start = 1'b0;
            if (s_addr !== prev) addr_log.push_back(int'(s_addr));
            prev = s_addr;
            if (s_wr) pend++;
            if (s_done && loop_mode) push_frame(4);
            if (frame_count == fc0 + 16'd2) loop_mode = 1'b0;
            if (!busy && pend == 0 && c > 2) break;
        end
        pix_wr_en = 1'b0;
        checks++;
        if (done_cnt - d0 != 3 || frame_count !== fc0 + 16'd3) begin
            failures++;
            $display("FAIL loop_frames got=%0d/%0d required=3/%0d", done_cnt - d0, frame_count, fc0 + 16'd3);
        end
        checks++;
        if (wr_cnt - w0 != 12 || exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loop_rays got=%0d left=%0d busy=%b required=12/0/0", wr_cnt - w0, exp_q.size(), busy);
        end
        checks++;
        if (addr_log.size() != 12) begin
            failures++;
            $display("FAIL loop_addr_len got=%0d required=12", addr_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (addr_log[i] != i % 4) begin
                    failures++;
                    $display("FAIL loop_addr idx=%0d got=%0d required=%0d", i, addr_log[i], i % 4);
                    break;
                end
            end
        end
    endtask

    task automatic test_ignored_starts();
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt; pend = 0;
        start = 1'b1; num_rays = 5'd0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (s_busy !== 1'b0 || s_wr !== 1'b0) begin
                failures++;
                $display("FAIL zero_start got=%b%b required=00", s_busy, s_wr);
            end
        end
        push_frame(3);
        start = 1'b1; num_rays = 5'd3;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; num_rays = 5'd6;
        tick();
        start = 1'b0;
        if (s_wr) pend++;
        run_with_pixels(60, 1'b0);
        checks++;
        if (wr_cnt - w0 != 3 || exp_q.size() != 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start got=%0d left=%0d done=%0d busy=%b required=3/0/1/0",
                     wr_cnt - w0, exp_q.size(), done_cnt - d0, busy);
        end
    endtask

    task automatic test_full_frame();
        int w0;
        w0 = wr_cnt; pend = 0;
        push_frame(16);
        start = 1'b1; num_rays = 5'd16;
        tick();
        start = 1'b0;
        run_with_pixels(300, 1'b1);
        checks++;
        if (wr_cnt - w0 != 16 || exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_frame got=%0d left=%0d busy=%b required=16/0/0", wr_cnt - w0, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_midframe();
        int w0;
        w0 = wr_cnt;
        push_frame(8);
        start = 1'b1; num_rays = 5'd8;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (wr_cnt - w0 >= 3) break;
            tick();
        end
        checks++;
        if (wr_cnt - w0 != 3) begin
            failures++;
            $display("FAIL pre_reset_rays got=%0d required=3", wr_cnt - w0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, out_wr_en, frame_done, pix_overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_flags got=%b required=0000", {busy, out_wr_en, frame_done, pix_overflow});
        end
        checks++;
        if (frame_count !== 16'd0 || ray_out !== '0 || rom_addr !== '0) begin
            failures++;
            $display("FAIL async_reset_values got=%0h/%0h/%0h required=0/0/0", frame_count, ray_out, rom_addr);
        end
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        w0 = wr_cnt; pend = 0;
        push_frame(8);
        start = 1'b1; num_rays = 5'd8;
        tick();
        start = 1'b0;
        run_with_pixels(80, 1'b0);
        checks++;
        if (wr_cnt - w0 != 8 || exp_q.size() != 0 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL after_reset got=%0d left=%0d frames=%0d required=8/0/1",
                     wr_cnt - w0, exp_q.size(), frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pixels();
        test_backpressure();
        test_loop();
        test_ignored_starts();
        test_full_frame();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
